// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC121S101 host controller.
package dac_ctrl_pkg;

    localparam int FRAME_W = 16;
    localparam int CODE_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] pd,
                                                       input logic [CODE_W-1:0] code);
        return {2'b00, pd, code};
    endfunction

endpackage

// File: rtl/dac_code_conv.sv
// Signed 16-bit sample -> 12-bit offset-binary DAC code with rounding and positive saturation.
// One register stage; no backpressure, out_vld simply follows in_vld by one cycle.
module dac_code_conv
    import dac_ctrl_pkg::*;
(
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic [15:0]       din,
    input  logic              in_vld,
    output logic [CODE_W-1:0] code,
    output logic              out_vld
);

    logic [15:0] sum;
    logic [15:0] sat;
    logic        ovf;
    logic        unused_lsb;

    // Adding +8 rounds to nearest; only a positive input can overflow.
    assign sum        = din + 16'd8;
    assign ovf        = ~din[15] & sum[15];
    assign sat        = ovf ? 16'h7FFF : sum;
    assign unused_lsb = ^sat[3:0];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            code    <= '0;
            out_vld <= 1'b0;
        end else begin
            code    <= {~sat[15], sat[14:4]};
            out_vld <= in_vld;
        end
    end

endmodule

// File: rtl/dac121s101_hctrl.sv
// Serialises signed samples into DAC121S101 frames (nSYNC/SCLK/DIN) with a 1-entry input buffer.
// nSYNC falls two edges after acceptance; DATA_READY drops while the buffer holds a word.
module dac121s101_hctrl
    import dac_ctrl_pkg::*;
#(
    parameter int HALF_PERIOD   = 8,
    parameter int SETUP_CYC     = 8,
    parameter int SYNC_HIGH_CYC = 4
) (
    input  logic        CLK_HIGH,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [15:0] DATA_IN,
    input  logic [1:0]  DATA_PD,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic        DAC_nSYNC,
    output logic        DAC_SCLK,
    output logic        DAC_DIN,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] BIT_LAST   = 16'(2 * HALF_PERIOD - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SYNC_HIGH_CYC - 1);
    localparam logic [15:0] GAP_MIN    = 16'(SYNC_HIGH_CYC);

    state_t               state;
    logic [15:0]          cnt;
    logic [3:0]           bit_idx;
    logic [FRAME_W-2:0]   shreg;
    logic                 run;
    logic                 buf_full;
    logic [15:0]          buf_dat;
    logic [1:0]           buf_pd;
    logic [CODE_W-1:0]    code;
    logic                 code_vld;
    logic                 conv_in_vld;
    logic                 accept;
    logic                 launch;
    logic [FRAME_W-1:0]   frame_new;

    assign DATA_READY  = EN & run & ~buf_full;
    assign accept      = DATA_VALID & DATA_READY;
    assign BUSY        = (state != IDLE) | buf_full;
    assign frame_new   = build_frame(buf_pd, code);
    // In IDLE, cnt tracks nSYNC high time so the first frame after reset still honours the gap.
    assign launch      = (state == IDLE) & EN & buf_full & code_vld & (cnt >= GAP_MIN);
    assign conv_in_vld = buf_full & EN & ~launch;

    dac_code_conv u_conv (
        .core_clk (CLK_HIGH),
        .arst_n   (RST_N),
        .din      (buf_dat),
        .in_vld   (conv_in_vld),
        .code     (code),
        .out_vld  (code_vld)
    );

    always_ff @(posedge CLK_HIGH or negedge RST_N) begin
        if (!RST_N) begin
            run      <= 1'b0;
            buf_full <= 1'b0;
            buf_dat  <= '0;
            buf_pd   <= '0;
        end else begin
            run <= 1'b1;
            if (!EN || launch) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
                buf_dat  <= DATA_IN;
                buf_pd   <= DATA_PD;
            end
        end
    end

    always_ff @(posedge CLK_HIGH or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            DAC_nSYNC  <= 1'b1;
            DAC_SCLK   <= 1'b1;
            DAC_DIN    <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shreg     <= frame_new[FRAME_W-2:0];
                        DAC_DIN   <= frame_new[FRAME_W-1];
                        DAC_nSYNC <= 1'b0;
                        DAC_SCLK  <= 1'b1;
                        bit_idx   <= '0;
                        cnt       <= '0;
                        state     <= SETUP;
                    end else if (cnt < GAP_MIN) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        DAC_SCLK <= 1'b0;
                    end
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        DAC_SCLK <= 1'b1;
                        if (bit_idx == 4'd15) begin
                            DAC_nSYNC  <= 1'b1;
                            DAC_DIN    <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            DAC_DIN <= shreg[FRAME_W-2];
                            shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= GAP_MIN;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac121s101_hctrl.sv
// Directed bench for dac121s101_hctrl: a pin-level monitor decodes frames, directed words check codes and timing.
module tb_dac121s101_hctrl;
    import dac_ctrl_pkg::*;

    logic        CLK_HIGH   = 1'b0;
    logic        RST_N      = 1'b0;
    logic        EN         = 1'b0;
    logic [15:0] DATA_IN    = '0;
    logic [1:0]  DATA_PD    = '0;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic        DAC_nSYNC;
    logic        DAC_SCLK;
    logic        DAC_DIN;
    logic        BUSY;
    logic        FRAME_DONE;

    dac121s101_hctrl dut (
        .CLK_HIGH   (CLK_HIGH),
        .RST_N      (RST_N),
        .EN         (EN),
        .DATA_IN    (DATA_IN),
        .DATA_PD    (DATA_PD),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .DAC_nSYNC  (DAC_nSYNC),
        .DAC_SCLK   (DAC_SCLK),
        .DAC_DIN    (DAC_DIN),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK_HIGH = ~CLK_HIGH;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin-level frame decoder, sampled on the falling edge of CLK_HIGH.
    logic        prev_sclk = 1'b1;
    logic        prev_din  = 1'b0;
    bit          in_frame  = 1'b0;
    logic [15:0] sh        = '0;
    int          low_cnt = 0, nbits = 0, high_cnt = 0, last_gap = 0;
    int          done_cnt = 0, stab_err = 0, idle_din_err = 0;
    logic [15:0] frm_q[$];
    int          low_q[$];
    int          nb_q[$];

    always @(negedge CLK_HIGH) begin
        if (!RST_N) begin
            in_frame = 1'b0;
            high_cnt = 0;
        end else begin
            if (DAC_nSYNC == 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    nbits    = 0;
                    sh       = '0;
                    last_gap = high_cnt;
                end
                low_cnt++;
                if (prev_sclk && !DAC_SCLK) begin
                    sh = {sh[14:0], DAC_DIN};
                    nbits++;
                    if (DAC_DIN !== prev_din) stab_err++;
                end
            end else begin
                if (in_frame) begin
                    frm_q.push_back(sh);
                    low_q.push_back(low_cnt);
                    nb_q.push_back(nbits);
                    in_frame = 1'b0;
                    high_cnt = 0;
                end
                high_cnt++;
                if (DAC_DIN !== 1'b0) idle_din_err++;
            end
            if (FRAME_DONE) done_cnt++;
        end
        prev_sclk = DAC_SCLK;
        prev_din  = DAC_DIN;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge CLK_HIGH);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic [1:0] pd, input string tag);
        int i = 0;
        DATA_IN    = d;
        DATA_PD    = pd;
        DATA_VALID = 1'b1;
        while (!DATA_READY && i < 2000) begin
            tick();
            i++;
        end
        check({tag, "_ready_seen"}, DATA_READY, 1);
        tick();
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int i = 0;
        while (frm_q.size() < n && i < 5000) begin
            tick();
            i++;
        end
        check({tag, "_frame_seen"}, frm_q.size() >= n, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nsync"}, DAC_nSYNC, 1);
        check({tag, "_sclk"},  DAC_SCLK, 1);
        check({tag, "_din"},   DAC_DIN, 0);
        check({tag, "_ready"}, DATA_READY, 0);
        check({tag, "_busy"},  BUSY, 0);
        check({tag, "_done"},  FRAME_DONE, 0);
    endtask

    initial begin
        int d0, nf, i;

        // Reset values with EN already high.
        EN = 1'b1;
        tick(2);
        check_reset_outputs("rst");
        RST_N = 1'b1;
        tick(6);
        check("idle_ready", DATA_READY, 1);

        // Mid-scale sample, launch latency and frame length.
        d0 = done_cnt;
        send_word(16'h0000, PD_NORMAL, "t1");
        check("t1_busy", BUSY, 1);
        tick();
        check("t1_sync_pre", DAC_nSYNC, 1);
        tick();
        check("t1_sync_fall", DAC_nSYNC, 0);
        wait_frames(1, "t1");
        tick(3);
        check("t1_frame", frm_q[0], 16'h0800);
        check("t1_low", low_q[0], 264);
        check("t1_bits", nb_q[0], 16);
        check("t1_done", done_cnt - d0, 1);

        // Saturation and negative full scale.
        send_word(16'h7FFF, PD_NORMAL, "t2a");
        wait_frames(2, "t2a");
        check("t2_sat", frm_q[1], 16'h0FFF);
        send_word(16'h8000, PD_NORMAL, "t2b");
        wait_frames(3, "t2b");
        check("t2_negfs", frm_q[2], 16'h0000);

        // PD bits in the frame, bits stable across SCLK falls.
        send_word(16'h1234, PD_HIZ, "t3");
        wait_frames(4, "t3");
        check("t3_frame", frm_q[3], 16'h3923);
        check("t3_bits", nb_q[3], 16);
        check("t3_stable", stab_err, 0);

        // Back-to-back words: second buffered during the first frame.
        tick(10);
        send_word(16'h4000, PD_1K, "t4a");
        send_word(16'hC000, PD_100K, "t4b");
        check("t4_in_frame", DAC_nSYNC, 0);
        check("t4_rdy_full", DATA_READY, 0);
        check("t4_busy", BUSY, 1);
        tick(100);
        check("t4_rdy_hold", DATA_READY, 0);
        wait_frames(6, "t4");
        check("t4_frame_a", frm_q[4], 16'h1C00);
        check("t4_frame_b", frm_q[5], 16'h2400);
        check("t4_gap", last_gap, 5);

        // Reset pulse at bit 7, then a clean frame after release.
        tick(10);
        d0 = done_cnt;
        nf = frm_q.size();
        send_word(16'h1234, PD_NORMAL, "t5a");
        i = 0;
        while (!(in_frame && nbits == 7) && i < 2000) begin
            tick();
            i++;
        end
        check("t5_bit7_reached", nbits, 7);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tick(3);
        RST_N = 1'b1;
        send_word(16'h0000, PD_NORMAL, "t5b");
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_aborted", frm_q.size(), nf);
        wait_frames(nf + 1, "t5b");
        tick(3);
        check("t5_frame", frm_q[nf], 16'h0800);
        check("t5_low", low_q[nf], 264);
        check("t5_gap", last_gap, 4);
        check("t5_done", done_cnt - d0, 1);

        // EN dropped mid-frame with a word buffered.
        tick(10);
        nf = frm_q.size();
        send_word(16'h0000, PD_NORMAL, "t6a");
        send_word(16'h7FFF, PD_NORMAL, "t6b");
        tick(50);
        EN = 1'b0;
        tick();
        check("t6_ready_off", DATA_READY, 0);
        check("t6_busy_frame", BUSY, 1);
        wait_frames(nf + 1, "t6");
        check("t6_frame", frm_q[nf], 16'h0800);
        check("t6_busy_hold", BUSY, 1);
        i = 0;
        while (BUSY && i < 100) begin
            tick();
            i++;
        end
        check("t6_busy_fall", i, 4);
        tick(600);
        check("t6_discarded", frm_q.size(), nf + 1);
        check("t6_idle_sync", DAC_nSYNC, 1);
        EN = 1'b1;
        tick();
        check("t6_ready_back", DATA_READY, 1);

        check("din_idle_zero", idle_din_err, 0);
        check("bits_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
